// File: rtl/pc_call_stack.sv
// Program counter with relative branch, CALL/RET return-address stack,
// stall hold and sticky error flag for the fetch path.
module pc_call_stack #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          OFF_W       = 8,
    parameter int unsigned          STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]    RESET_ADDR  = '0,
    localparam int unsigned         SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic [OFF_W-1:0]  offset,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] pc_out,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              err
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BREL = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              full, empty;
    logic              push, new_err;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] off_ext;
    op_e               op_v;

    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);
    assign ret_addr = pc_q + ADDR_W'(1);
    assign off_ext  = ADDR_W'($signed(offset));
    assign op_v     = op_e'(op);

    // Top-of-stack read as a compare mux, so sp never indexes past the array.
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) top = stack_q[i];
        end
    end

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        new_err = 1'b0;
        if (!stall) begin
            case (op_v)
                OP_NOP:  ;
                OP_INC:  pc_d = ret_addr;
                OP_JMP:  pc_d = target;
                OP_BREL: pc_d = pc_q + off_ext;
                OP_CALL: begin
                    if (full) begin
                        new_err = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        new_err = 1'b1;
                    end else begin
                        pc_d = top;
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                default: new_err = 1'b1;
            endcase
            if (new_err)      err_d = 1'b1;
            else if (clr_err) err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_ADDR;
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (push && sp_q == SP_W'(i)) stack_q[i] <= ret_addr;
            end
        end
    end

    assign pc_out      = pc_q;
    assign sp          = sp_q;
    assign err         = err_q;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: reference model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_pc_call_stack;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          stall = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [AW-1:0] target = '0;
    logic [7:0]    offset = '0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] pc_out;
    logic [2:0]    sp;
    logic          stack_full, stack_empty, err;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    pc_call_stack #(
        .ADDR_W(AW), .OFF_W(8), .STACK_DEPTH(DEPTH), .RESET_ADDR(8'h00)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .op(op),
        .target(target), .offset(offset), .clr_err(clr_err),
        .pc_out(pc_out), .sp(sp), .stack_full(stack_full),
        .stack_empty(stack_empty), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: return addresses kept in a plain list with a count.
    logic [AW-1:0] m_pc;
    int            m_n;
    logic          m_err;
    logic [AW-1:0] m_stk [DEPTH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc  <= 8'h00;
            m_n   <= 0;
            m_err <= 1'b0;
        end else if (!stall) begin
            if (clr_err) m_err <= 1'b0;
            case (op)
                3'd1: m_pc <= AW'(int'(m_pc) + 1);
                3'd2: m_pc <= target;
                3'd3: m_pc <= AW'(int'(m_pc) + int'($signed(offset)));
                3'd4: begin
                    if (m_n == DEPTH) m_err <= 1'b1;
                    else begin
                        m_stk[m_n] <= AW'(int'(m_pc) + 1);
                        m_n        <= m_n + 1;
                        m_pc       <= target;
                    end
                end
                3'd5: begin
                    if (m_n == 0) m_err <= 1'b1;
                    else begin
                        m_pc <= m_stk[m_n - 1];
                        m_n  <= m_n - 1;
                    end
                end
                3'd6, 3'd7: m_err <= 1'b1;
                default: ;
            endcase
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc",    int'(pc_out),      int'(m_pc));
            check("model_sp",    int'(sp),          m_n);
            check("model_err",   int'(err),         int'(m_err));
            check("model_full",  int'(stack_full),  int'(m_n == DEPTH));
            check("model_empty", int'(stack_empty), int'(m_n == 0));
        end
    end

    task automatic apply(input logic [2:0] o, input logic [7:0] t,
                         input logic [7:0] f, input logic c, input logic s);
        op = o; target = t; offset = f; clr_err = c; stall = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_pc", int'(pc_out), 'h00);
        check("rst_sp", int'(sp), 0);
        check("rst_empty", int'(stack_empty), 1);
        check("rst_full", int'(stack_full), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // JMP then INC wrapping through 0xFF
        apply(3'd2, 8'hFE, 8'h00, 1'b0, 1'b0); check("jmp_fe", int'(pc_out), 'hFE);
        apply(3'd1, 8'h00, 8'h00, 1'b0, 1'b0); check("inc_ff", int'(pc_out), 'hFF);
        apply(3'd1, 8'h00, 8'h00, 1'b0, 1'b0); check("inc_00", int'(pc_out), 'h00);
        apply(3'd1, 8'h00, 8'h00, 1'b0, 1'b0); check("inc_01", int'(pc_out), 'h01);
        check("inc_err", int'(err), 0);

        // Signed relative branches
        apply(3'd2, 8'h10, 8'h00, 1'b0, 1'b0);
        apply(3'd3, 8'h00, 8'hF0, 1'b0, 1'b0); check("brel_neg", int'(pc_out), 'h00);
        apply(3'd3, 8'h00, 8'h7F, 1'b0, 1'b0); check("brel_pos", int'(pc_out), 'h7F);

        // Nested CALL/RET
        apply(3'd2, 8'h20, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h80, 8'h00, 1'b0, 1'b0); check("call1_pc", int'(pc_out), 'h80); check("call1_sp", int'(sp), 1);
        apply(3'd4, 8'h90, 8'h00, 1'b0, 1'b0); check("call2_pc", int'(pc_out), 'h90); check("call2_sp", int'(sp), 2);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0); check("ret1_pc", int'(pc_out), 'h81);  check("ret1_sp", int'(sp), 1);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0); check("ret2_pc", int'(pc_out), 'h21);  check("ret2_sp", int'(sp), 0);

        // Asynchronous reset mid-run with pc=0x37, sp=2
        apply(3'd2, 8'h10, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h20, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h37, 8'h00, 1'b0, 1'b0);
        check("pre_rst_pc", int'(pc_out), 'h37);
        check("pre_rst_sp", int'(sp), 2);
        op = 3'd1;
        reset_n = 1'b0;
        #1;
        check("async_rst_pc", int'(pc_out), 'h00);
        check("async_rst_sp", int'(sp), 0);
        check("async_rst_err", int'(err), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Fill the stack, overflow, then clear error together with RET
        apply(3'd2, 8'h40, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h50, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h60, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h70, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h80, 8'h00, 1'b0, 1'b0);
        check("fill_full", int'(stack_full), 1);
        apply(3'd4, 8'h55, 8'h00, 1'b0, 1'b0);
        check("ovf_pc", int'(pc_out), 'h80);
        check("ovf_sp", int'(sp), 4);
        check("ovf_err", int'(err), 1);
        apply(3'd5, 8'h00, 8'h00, 1'b1, 1'b0);
        check("clr_ret_err", int'(err), 0);
        check("clr_ret_pc", int'(pc_out), 'h71);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0); check("pop_61", int'(pc_out), 'h61);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0); check("pop_51", int'(pc_out), 'h51);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0); check("pop_41", int'(pc_out), 'h41);

        // Underflow: set wins over clr_err
        apply(3'd5, 8'h00, 8'h00, 1'b1, 1'b0);
        check("udf_err", int'(err), 1);
        check("udf_pc", int'(pc_out), 'h41);
        apply(3'd0, 8'h00, 8'h00, 1'b1, 1'b1); check("stall_clr_held", int'(err), 1);
        apply(3'd0, 8'h00, 8'h00, 1'b1, 1'b0); check("clr_err", int'(err), 0);

        // Stall holds everything, including illegal-op error
        apply(3'd6, 8'h00, 8'h00, 1'b0, 1'b1);
        check("stall_ill_err", int'(err), 0);
        check("stall_ill_pc", int'(pc_out), 'h41);
        for (int i = 0; i < 3; i++) begin
            apply(3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
            check("stall_inc_pc", int'(pc_out), 'h41);
        end
        apply(3'd7, 8'h00, 8'h00, 1'b0, 1'b0); check("illegal_err", int'(err), 1);
        check("illegal_pc", int'(pc_out), 'h41);
        apply(3'd0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Return address wraps at the top of the address space
        apply(3'd2, 8'hFF, 8'h00, 1'b0, 1'b0);
        apply(3'd4, 8'h10, 8'h00, 1'b0, 1'b0);
        apply(3'd5, 8'h00, 8'h00, 1'b0, 1'b0);
        check("call_wrap_pc", int'(pc_out), 'h00);
        check("call_wrap_err", int'(err), 0);
        apply(3'd3, 8'h00, 8'h80, 1'b0, 1'b0); check("brel_min", int'(pc_out), 'h80);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
